// File: rtl/id_stage_hzd_if.sv
// IF/ID latch bundle presented to the decode stage.
// IF drives the instruction side; ID returns the load-use stall.
interface id_stage_hzd_if #(
    parameter int DATA_W = 32
);
    logic              if_id_valid;
    logic [31:0]       if_id_instr;
    logic [DATA_W-1:0] if_id_npc;
    logic              stall_if;

    modport master (
        output if_id_valid,
        output if_id_instr,
        output if_id_npc,
        input  stall_if
    );

    modport slave (
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_npc,
        output stall_if
    );
endinterface

// File: rtl/id_stage_hzd.sv
// Decode stage: regfile, control decode, load-use hazard, ID/EX latch.
// Optional macro ID_WB_BYPASS_EN: same-cycle writeback write-through.
module id_stage_hzd #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    id_stage_hzd_if.slave      ifid,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    input  logic               hold,
    output logic               id_ex_valid,
    output logic [1:0]         id_ex_wb,
    output logic [2:0]         id_ex_mem,
    output logic [3:0]         id_ex_ex,
    output logic [DATA_W-1:0]  id_ex_npc,
    output logic [DATA_W-1:0]  id_ex_rd1,
    output logic [DATA_W-1:0]  id_ex_rd2,
    output logic [DATA_W-1:0]  id_ex_imm,
    output logic [RADDR_W-1:0] id_ex_rs,
    output logic [RADDR_W-1:0] id_ex_rt,
    output logic [RADDR_W-1:0] id_ex_rd
);
    localparam int NREG = 2 ** RADDR_W;

    logic [DATA_W-1:0]  rf_q [NREG];
    logic [5:0]         op;
    logic [RADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]  rd1, rd2, imm;
    logic [1:0]         wb_c;
    logic [2:0]         mem_c;
    logic [3:0]         ex_c;
    logic               wr_en, hazard, bubble;

    logic               valid_q, valid_d;
    logic [1:0]         wb_q, wb_d;
    logic [2:0]         mem_q, mem_d;
    logic [3:0]         ex_q, ex_d;
    logic [DATA_W-1:0]  npc_q, rd1_q, rd2_q, imm_q;
    logic [RADDR_W-1:0] rs_q, rt_q, rd_q;

    assign op    = ifid.if_id_instr[31:26];
    assign rs    = RADDR_W'(ifid.if_id_instr[25:21]);
    assign rt    = RADDR_W'(ifid.if_id_instr[20:16]);
    assign rd    = RADDR_W'(ifid.if_id_instr[15:11]);
    assign imm   = {{(DATA_W-16){ifid.if_id_instr[15]}}, ifid.if_id_instr[15:0]};
    assign wr_en = wb_reg_write && (wb_rd != '0);

`ifdef ID_WB_BYPASS_EN
    assign rd1 = (rs == '0) ? '0 : (wr_en && wb_rd == rs) ? wb_data : rf_q[rs];
    assign rd2 = (rt == '0) ? '0 : (wr_en && wb_rd == rt) ? wb_data : rf_q[rt];
`else
    assign rd1 = (rs == '0) ? '0 : rf_q[rs];
    assign rd2 = (rt == '0) ? '0 : rf_q[rt];
`endif

    always_comb begin
        wb_c  = '0;
        mem_c = '0;
        ex_c  = '0;
        unique case (1'b1)
            op == 6'b000000: begin wb_c = 2'b01; ex_c = 4'b1100; end
            op == 6'b100011: begin wb_c = 2'b11; mem_c = 3'b010; ex_c = 4'b0001; end
            op == 6'b101011: begin mem_c = 3'b001; ex_c = 4'b0001; end
            op == 6'b000100: begin mem_c = 3'b100; ex_c = 4'b0100; end
            op == 6'b001000: begin wb_c = 2'b01; ex_c = 4'b0011; end
            default: ;
        endcase
    end

    // Load in EX whose destination feeds either source in ID.
    assign hazard = valid_q && mem_q[1] && (rt_q != '0) && ifid.if_id_valid &&
                    ((rt_q == rs) || (rt_q == rt));
    assign ifid.stall_if = hazard && !flush && !hold;
    assign bubble = flush || hazard || !ifid.if_id_valid;

    always_comb begin
        valid_d = ifid.if_id_valid && !flush && !hazard;
        wb_d    = bubble ? 2'b00 : wb_c;
        mem_d   = bubble ? 3'b000 : mem_c;
        ex_d    = bubble ? 4'b0000 : ex_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            mem_q   <= '0;
            ex_q    <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else if (!hold) begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            mem_q   <= mem_d;
            ex_q    <= ex_d;
            npc_q   <= ifid.if_id_npc;
            rd1_q   <= rd1;
            rd2_q   <= rd2;
            imm_q   <= imm;
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
        end
    end

    assign id_ex_valid = valid_q;
    assign id_ex_wb    = wb_q;
    assign id_ex_mem   = mem_q;
    assign id_ex_ex    = ex_q;
    assign id_ex_npc   = npc_q;
    assign id_ex_rd1   = rd1_q;
    assign id_ex_rd2   = rd2_q;
    assign id_ex_imm   = imm_q;
    assign id_ex_rs    = rs_q;
    assign id_ex_rt    = rt_q;
    assign id_ex_rd    = rd_q;
endmodule

// File: tb/tb_id_stage_hzd.sv
// Directed bench for id_stage_hzd: decode, regfile, load-use, flush/hold, reset.
// Expected values are hand-computed from the instruction encodings.
module tb_id_stage_hzd;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_reg_write;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush, hold;
    logic          id_ex_valid;
    logic [1:0]    id_ex_wb;
    logic [2:0]    id_ex_mem;
    logic [3:0]    id_ex_ex;
    logic [DW-1:0] id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm;
    logic [AW-1:0] id_ex_rs, id_ex_rt, id_ex_rd;

    int checks = 0;
    int errors = 0;

    id_stage_hzd_if #(.DATA_W(DW)) ifid ();

    id_stage_hzd #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ifid(ifid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .hold(hold),
        .id_ex_valid(id_ex_valid), .id_ex_wb(id_ex_wb),
        .id_ex_mem(id_ex_mem), .id_ex_ex(id_ex_ex),
        .id_ex_npc(id_ex_npc), .id_ex_rd1(id_ex_rd1),
        .id_ex_rd2(id_ex_rd2), .id_ex_imm(id_ex_imm),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input int s, input int t, input int d);
        return {6'b000000, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input int s,
                                          input int t, input logic [15:0] i);
        return {o, 5'(s), 5'(t), i};
    endfunction

    task automatic wb(input logic en, input int r, input logic [31:0] d);
        wb_reg_write = en;
        wb_rd        = AW'(r);
        wb_data      = d;
    endtask

    task automatic put(input logic v, input logic [31:0] ins);
        ifid.if_id_valid = v;
        ifid.if_id_instr = ins;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        hold = 1'b0;
        wb(1'b0, 0, 0);
        put(1'b0, 32'h0);
        ifid.if_id_npc = 32'h0;
        #12;
        chk("rst_valid", id_ex_valid, 0);
        chk("rst_rd1", id_ex_rd1, 0);
        chk("rst_stall", ifid.stall_if, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic RTYPE decode and register read
        step();
        wb(1'b1, 1, 32'h11);
        step();
        wb(1'b1, 2, 32'h22);
        step();
        wb(1'b0, 0, 0);
        put(1'b1, rtype(1, 2, 3));
        ifid.if_id_npc = 32'h104;
        step();
        chk("r_rd1", id_ex_rd1, 32'h11);
        chk("r_rd2", id_ex_rd2, 32'h22);
        chk("r_wb", id_ex_wb, 2'b01);
        chk("r_mem", id_ex_mem, 3'b000);
        chk("r_ex", id_ex_ex, 4'b1100);
        chk("r_rd", id_ex_rd, 3);
        chk("r_valid", id_ex_valid, 1);
        chk("r_npc", id_ex_npc, 32'h104);

        // Load-use: LW r4 then ADD using r4
        put(1'b1, itype(6'b100011, 0, 4, 16'h0008));
        step();
        chk("lw_wb", id_ex_wb, 2'b11);
        chk("lw_mem", id_ex_mem, 3'b010);
        chk("lw_ex", id_ex_ex, 4'b0001);
        chk("lw_imm", id_ex_imm, 32'h8);
        put(1'b1, rtype(4, 1, 7));
        #1;
        chk("lu_stall", ifid.stall_if, 1);
        step();
        chk("bub_valid", id_ex_valid, 0);
        chk("bub_ctl", {id_ex_wb, id_ex_mem, id_ex_ex}, 0);
        chk("bub_stall", ifid.stall_if, 0);
        step();
        chk("add_valid", id_ex_valid, 1);
        chk("add_rs", id_ex_rs, 4);
        chk("add_rd", id_ex_rd, 7);
        chk("add_ex", id_ex_ex, 4'b1100);

        // LW into r0 never stalls
        put(1'b1, itype(6'b100011, 1, 0, 16'h0));
        step();
        put(1'b1, rtype(0, 0, 9));
        #1;
        chk("r0_nostall", ifid.stall_if, 0);

        // Flush masks the stall of a load-use pair
        put(1'b1, itype(6'b100011, 0, 4, 16'h0));
        step();
        put(1'b1, rtype(4, 0, 9));
        flush = 1'b1;
        #1;
        chk("fl_stall", ifid.stall_if, 0);
        flush = 1'b0;

        // Same-cycle writeback read of r5
        put(1'b1, rtype(0, 0, 0));
        wb(1'b1, 5, 32'h1234);
        step();
        wb(1'b1, 5, 32'hDEAD);
        put(1'b1, rtype(5, 0, 8));
        step();
`ifdef ID_WB_BYPASS_EN
        chk("byp_rd1", id_ex_rd1, 32'hDEAD);
`else
        chk("byp_rd1", id_ex_rd1, 32'h1234);
`endif
        wb(1'b0, 0, 0);
        step();
        chk("r5_new", id_ex_rd1, 32'hDEAD);

        // r0 write ignored
        wb(1'b1, 0, 32'hFFFF);
        put(1'b1, rtype(0, 0, 1));
        step();
        wb(1'b0, 0, 0);
        step();
        chk("r0_rd1", id_ex_rd1, 0);
        chk("r0_rd2", id_ex_rd2, 0);

        // Flush with LW in ID
        put(1'b1, itype(6'b100011, 1, 9, 16'h4));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", id_ex_valid, 0);
        chk("fl_mem", id_ex_mem, 3'b000);

        // ADDI with negative immediate, then hold 3 cycles
        put(1'b1, itype(6'b001000, 1, 10, 16'hFFF0));
        step();
        chk("ad_wb", id_ex_wb, 2'b01);
        chk("ad_ex", id_ex_ex, 4'b0011);
        chk("ad_imm", id_ex_imm, 32'hFFFF_FFF0);
        chk("ad_rd1", id_ex_rd1, 32'h11);
        hold = 1'b1;
        wb(1'b1, 6, 32'h66);
        put(1'b1, rtype(6, 2, 11));
        for (int i = 0; i < 3; i++) begin
            step();
            wb(1'b0, 0, 0);
            chk("hd_valid", id_ex_valid, 1);
            chk("hd_ex", id_ex_ex, 4'b0011);
            chk("hd_imm", id_ex_imm, 32'hFFFF_FFF0);
            chk("hd_rd1", id_ex_rd1, 32'h11);
        end
        hold = 1'b0;
        step();
        chk("r6_rd1", id_ex_rd1, 32'h66);
        chk("r6_rd", id_ex_rd, 11);

        // Async reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", id_ex_valid, 0);
        chk("ar_rd1", id_ex_rd1, 0);
        chk("ar_wb", id_ex_wb, 0);
        chk("ar_stall", ifid.stall_if, 0);
        @(negedge clk);
        rst = 1'b1;
        put(1'b1, rtype(1, 6, 12));
        step();
        chk("post_valid", id_ex_valid, 1);
        chk("post_rd1", id_ex_rd1, 0);
        chk("post_rd2", id_ex_rd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
